dsram_bus_bridge: RTL and testbench

- Sits directly downstream of the CPU core's data-SRAM port. Converts the core's single-cycle SRAM-style access into a req/addr_ok/data_ok handshake bus.
- Inputs: data_sram_en, wen, addr, wdata.
- Returns load data to the core, and raises stallreq toward CTRL while an access is outstanding.
- Allows one outstanding transaction; no buffering beyond a single read-data register.

---
 rtl/dsram_bus_bridge.sv | 157 +++++++++++++++
 tb/tb_dsram_bus_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dsram_bus_bridge
// Description : Converts the core's single-cycle data-SRAM access into a
//               req/addr_ok/data_ok bus handshake, one transaction in flight.
//               Optional watchdog: define DSRAM_BRIDGE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dsram_bus_bridge #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_en,
    input  logic [3:0]        core_wen,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              stallreq,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [31:0]       bus_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [31:0] c_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              w_is_read;
    logic              w_active;
    logic              w_data_done;
    logic              w_timeout;
    logic [1:0]        w_size;

    // The watchdog counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("dsram_bus_bridge: TIMEOUT_CYC must be in 1..65535");
    end

    assign w_is_read   = (r_wen == 4'b0000);
    assign w_active    = (r_state != S_IDLE);
    assign w_data_done = ((r_state == S_REQ) && bus_addr_ok && bus_data_ok) ||
                         ((r_state == S_WAIT) && bus_data_ok);

`ifdef DSRAM_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] c_WDOG_LIMIT = 16'(TIMEOUT_CYC);

    logic [15:0] r_wdog;
    logic        r_err;

    // r_wdog equals the number of cycles spent so far in REQ/WAIT.
    assign w_timeout = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                       !w_data_done && (r_wdog == c_WDOG_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog <= 16'd0;
            r_err  <= 1'b0;
        end else begin
            if ((w_state_next == S_REQ) || (w_state_next == S_WAIT)) begin
                r_wdog <= r_wdog + 16'd1;
            end else begin
                r_wdog <= 16'd0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (core_en) w_state_next = S_REQ;
            S_REQ: begin
                if (bus_addr_ok) begin
                    w_state_next = bus_data_ok ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: if (bus_data_ok) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_wen   <= 4'b0000;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            // Only IDLE accepts a new access; core inputs seen in DONE are stale.
            if ((r_state == S_IDLE) && core_en) begin
                r_wen   <= core_wen;
                r_addr  <= core_addr;
                r_wdata <= core_wdata;
            end
            if (w_data_done && w_is_read) begin
                r_rdata <= bus_rdata;
            end else if (w_timeout && w_is_read) begin
                r_rdata <= c_TIMEOUT_RDATA;
            end
        end
    end

    always_comb begin
        w_size = 2'd2;
        case (r_wen)
            4'b0011, 4'b1100:                   w_size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = 2'd0;
            default:                            w_size = 2'd2;
        endcase
    end

    assign bus_req    = (r_state == S_REQ);
    assign bus_wr     = w_active & (|r_wen);
    assign bus_size   = w_active ? w_size : 2'd0;
    assign bus_wstrb  = w_active ? r_wen : 4'b0000;
    assign bus_addr   = w_active ? r_addr : '0;
    assign bus_wdata  = w_active ? r_wdata : 32'd0;
    assign core_rdata = r_rdata;
    assign stallreq   = ((r_state == S_IDLE) && core_en) ||
                        (r_state == S_REQ) || (r_state == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_dsram_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsram_bus_bridge
// Description : Self-checking bench for dsram_bus_bridge with a scoreboard of
//               expected request fields and returned load data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsram_bus_bridge;

    localparam int ADDR_W = 32;

    logic              clk         = 1'b0;
    logic              rst         = 1'b0;
    logic              core_en     = 1'b0;
    logic [3:0]        core_wen    = 4'b0000;
    logic [ADDR_W-1:0] core_addr   = '0;
    logic [31:0]       core_wdata  = 32'd0;
    logic [31:0]       core_rdata;
    logic              stallreq;
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [3:0]        bus_wstrb;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_addr_ok = 1'b0;
    logic              bus_data_ok = 1'b0;
    logic [31:0]       bus_rdata   = 32'd0;
    logic              bus_err;

    always #5 clk = ~clk;

    dsram_bus_bridge #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (255)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .core_en     (core_en),
        .core_wen    (core_wen),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .stallreq    (stallreq),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_wstrb   (bus_wstrb),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .bus_err     (bus_err)
    );

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        sb_q[$];
    logic [31:0] model_rdata = 32'd0;
    int          n_checks    = 0;
    int          n_pass      = 0;
    int          req_pulses  = 0;
    logic        prev_req    = 1'b0;

    // Counts request launches, so a re-issue in DONE shows up as an extra pulse.
    always @(negedge clk) begin
        prev_req <= bus_req;
        if (bus_req && !prev_req) begin
            req_pulses <= req_pulses + 1;
        end
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_size(input logic [3:0] wen);
        case (wen)
            4'b0011, 4'b1100:                   return 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
            default:                            return 2'd2;
        endcase
    endfunction

    // Issue one access, play the slave with the given latencies, and retire it.
    task automatic run_access(input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int a_lat, input int d_lat,
                              output int stall_n, output int req_n);
        txn_t t;
        txn_t e;
        int   wait_n;
        bit   in_wait;
        bit   done;
        t.wen   = wen;
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = (wen == 4'b0000) ? rdata : model_rdata;
        model_rdata = t.rdata;
        sb_q.push_back(t);

        @(negedge clk);
        core_en    = 1'b1;
        core_wen   = wen;
        core_addr  = addr;
        core_wdata = wdata;
        #1;
        stall_n = int'(stallreq);
        req_n   = 0;
        wait_n  = 0;
        in_wait = 1'b0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            #1;
            if (!stallreq) begin
                done = 1'b1;
            end else begin
                stall_n++;
                if (bus_req) begin
                    e = sb_q[0];
                    chk("req_fields",
                        80'({bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}),
                        80'({|e.wen, exp_size(e.wen), e.wen, e.addr, e.wdata}));
                    if (req_n == a_lat) begin
                        bus_addr_ok = 1'b1;
                        if (d_lat == 0) begin
                            bus_data_ok = 1'b1;
                            bus_rdata   = rdata;
                        end else begin
                            in_wait = 1'b1;
                        end
                    end
                    req_n++;
                end else if (in_wait) begin
                    wait_n++;
                    if (wait_n == d_lat) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = rdata;
                    end
                end
            end
        end
        e = sb_q.pop_front();
        chk("access_done", 80'(done), 80'(1));
        chk("done_req_low", 80'(bus_req), 80'(0));
        chk("core_rdata", 80'(core_rdata), 80'(e.rdata));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        core_en  = 1'b0;
        core_wen = 4'b0000;
        #1;
        chk("idle_req", 80'(bus_req), 80'(0));
        chk("idle_stall", 80'(stallreq), 80'(0));
    endtask

    initial begin
        int         s;
        int         r;
        int         p0;
        logic [3:0] wen_tbl [6];
        wen_tbl = '{4'b1100, 4'b0111, 4'b0011, 4'b0001, 4'b1000, 4'b1010};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdata", 80'(core_rdata), 80'(0));
        chk("rst_stall", 80'(stallreq), 80'(0));
        chk("rst_err", 80'(bus_err), 80'(0));
        chk("rst_bus", 80'({bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}), 80'(0));
        @(negedge clk);
        rst = 1'b1;

        // Word read, zero-wait slave
        run_access(4'b0000, 32'h8000_0100, 32'd0, 32'h1234_5678, 0, 0, s, r);
        chk("rd0_stall", 80'(s), 80'(2));
        chk("rd0_req", 80'(r), 80'(1));
        idle_cycle();

        // Byte store, delayed slave; bus_rdata garbage must not be captured
        run_access(4'b0100, 32'h8000_0102, 32'h00AB_0000, 32'hFFFF_0000, 3, 2, s, r);
        chk("st_stall", 80'(s), 80'(7));
        chk("st_req", 80'(r), 80'(4));
        idle_cycle();

        // Back-to-back reads: the second is presented right after DONE
        p0 = req_pulses;
        run_access(4'b0000, 32'h0000_0100, 32'd0, 32'hAAAA_5555, 1, 1, s, r);
        run_access(4'b0000, 32'h0000_0104, 32'd0, 32'h0BAD_F00D, 0, 0, s, r);
        idle_cycle();
        chk("b2b_pulses", 80'(req_pulses - p0), 80'(2));

        // Strobe patterns
        for (int i = 0; i < 6; i++) begin
            run_access(wen_tbl[i], 32'h8000_0200 + 32'(i * 4), 32'h5A5A_0000 + 32'(i),
                       32'h7777_7777, i % 3, i % 2, s, r);
            idle_cycle();
        end

        // Reset while in WAIT, then a late data_ok
        @(negedge clk);
        core_en   = 1'b1;
        core_wen  = 4'b0000;
        core_addr = 32'h8000_0300;
        @(negedge clk);
        #1;
        chk("mid_req", 80'(bus_req), 80'(1));
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0;
        core_en     = 1'b0;
        #1;
        chk("mid_wait_stall", 80'(stallreq), 80'(1));
        rst = 1'b0;
        @(negedge clk);
        rst         = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hFFFF_FFFF;
        #1;
        chk("post_rst_stall", 80'(stallreq), 80'(0));
        chk("post_rst_req", 80'(bus_req), 80'(0));
        @(negedge clk);
        bus_data_ok = 1'b0;
        #1;
        chk("post_rst_rdata", 80'(core_rdata), 80'(0));
        chk("post_rst_stall2", 80'(stallreq), 80'(0));
        model_rdata = 32'd0;

        // Recovery read after reset
        run_access(4'b0000, 32'h8000_0400, 32'd0, 32'hCAFE_0001, 2, 0, s, r);
        chk("rec_stall", 80'(s), 80'(4));
        idle_cycle();
        chk("final_err", 80'(bus_err), 80'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
`default_nettype wire
